// File: rtl/ptb2_axi4_lite_master.sv
`timescale 1ns/1ps
// AXI4-Lite single-outstanding master: turns cmd_* requests into one AW/W or AR transaction, returns one rsp_* each.
// Latency: cmd accept at cycle 0, AW/W or AR valid at 1, rsp_valid at 3 behind a zero-wait slave.
// Backpressure: cmd_ready only in IDLE; rsp_* held until rsp_ready; a watchdog aborts waits on a hung slave.
module ptb2_axi4_lite_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_TIMEOUT          = 16
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESET,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                        rsp_resp,
    output logic                              rsp_timeout,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);
    localparam int SW = C_M_AXI_DATA_WIDTH / 8;
    localparam int CW = (C_TIMEOUT > 1) ? $clog2(C_TIMEOUT) : 1;
    localparam logic [CW-1:0] WD_LAST = CW'((C_TIMEOUT > 0) ? C_TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RESP} state_t;
    state_t state, state_nxt;

    logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q;
    logic [C_M_AXI_DATA_WIDTH-1:0] wdata_q;
    logic [SW-1:0]                 wstrb_q;
    logic                          aw_done, w_done;
    logic [CW-1:0]                 wd_cnt;
    logic                          abort;

    wire cmd_hs     = cmd_valid & cmd_ready;
    wire aw_hs      = M_AXI_AWVALID & M_AXI_AWREADY;
    wire w_hs       = M_AXI_WVALID & M_AXI_WREADY;
    wire b_hs       = M_AXI_BVALID & M_AXI_BREADY;
    wire ar_hs      = M_AXI_ARVALID & M_AXI_ARREADY;
    wire r_hs       = M_AXI_RVALID & M_AXI_RREADY;
    // Both write channels finished, counting a handshake landing this very cycle.
    wire wr_both    = (aw_done | aw_hs) & (w_done | w_hs);
    wire in_wait    = (state == WR_REQ) | (state == WR_RESP) | (state == RD_REQ) | (state == RD_DATA);
    wire wd_expired = in_wait & (C_TIMEOUT != 0) & (wd_cnt == WD_LAST);

    assign M_AXI_AWADDR = addr_q;
    assign M_AXI_ARADDR = addr_q;
    assign M_AXI_WDATA  = wdata_q;
    assign M_AXI_WSTRB  = wstrb_q;

    // State register; reset wins over everything and discards any in-flight command.
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) state <= IDLE;
        else              state <= state_nxt;
    end

    // Next state: progress on handshakes first, watchdog abort only when nothing completed.
    always_comb begin
        state_nxt = state;
        abort     = 1'b0;
        case (state)
            IDLE:    if (cmd_hs) state_nxt = cmd_write ? WR_REQ : RD_REQ;
            WR_REQ:  if (wr_both) state_nxt = WR_RESP; else if (wd_expired) abort = 1'b1;
            WR_RESP: if (b_hs)    state_nxt = RESP;    else if (wd_expired) abort = 1'b1;
            RD_REQ:  if (ar_hs)   state_nxt = RD_DATA; else if (wd_expired) abort = 1'b1;
            RD_DATA: if (r_hs)    state_nxt = RESP;    else if (wd_expired) abort = 1'b1;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = RESP;
    end

    // Outputs decoded from the registered state, so every VALID/READY is glitch-free.
    always_comb begin
        cmd_ready     = (state == IDLE) & ~M_AXI_ARESET;
        M_AXI_AWVALID = (state == WR_REQ) & ~aw_done;
        M_AXI_WVALID  = (state == WR_REQ) & ~w_done;
        M_AXI_BREADY  = (state == WR_RESP);
        M_AXI_ARVALID = (state == RD_REQ);
        M_AXI_RREADY  = (state == RD_DATA);
        rsp_valid     = (state == RESP);
    end

    // Capture the command and track the independent AW and W handshakes.
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (cmd_hs) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (state == WR_REQ) begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
        end
    end

    // Watchdog: restarts on every state change, counts cycles spent waiting on the slave.
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET)                       wd_cnt <= '0;
        else if (state_nxt != state)            wd_cnt <= '0;
        else if (in_wait && (C_TIMEOUT != 0))   wd_cnt <= wd_cnt + 1'b1;
    end

    // Response capture; each new response overwrites the previous timeout flag.
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            rsp_rdata   <= '0;
            rsp_resp    <= 2'b00;
            rsp_timeout <= 1'b0;
        end else if (abort) begin
            rsp_rdata   <= '0;
            rsp_resp    <= 2'b11;
            rsp_timeout <= 1'b1;
        end else if (b_hs) begin
            rsp_rdata   <= '0;
            rsp_resp    <= M_AXI_BRESP;
            rsp_timeout <= 1'b0;
        end else if (r_hs) begin
            rsp_rdata   <= M_AXI_RDATA;
            rsp_resp    <= M_AXI_RRESP;
            rsp_timeout <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ptb2_axi4_lite_master.sv
`timescale 1ns/1ps
// Bench for ptb2_axi4_lite_master: directed commands against a configurable slave model.
// Expected responses are queued at issue time and popped by a monitor on each rsp handshake.
// Per-transaction cycle offsets and signal stability are recorded at negedge and checked after each command.
module tb_ptb2_axi4_lite_master;
    logic        clk = 1'b0;
    logic        M_AXI_ARESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
    logic        M_AXI_AWREADY = 1'b0, M_AXI_WREADY = 1'b0, M_AXI_ARREADY = 1'b0;
    logic        M_AXI_BVALID = 1'b0, M_AXI_RVALID = 1'b0;
    logic [1:0]  M_AXI_BRESP = 2'b00, M_AXI_RRESP = 2'b00;
    logic [31:0] M_AXI_RDATA = 32'h0;

    ptb2_axi4_lite_master #(.C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32), .C_TIMEOUT(16)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(M_AXI_ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
        .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
        .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
        .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        to;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    int n_chk = 0, n_pass = 0, n_rsp = 0, cyc = 0;
    // slave configuration
    int aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
    bit b_never = 0, r_never = 0;
    logic [31:0] rdata_cfg = 32'h0;
    logic [1:0]  resp_cfg = 2'b00;
    logic [31:0] cur_addr = 32'h0, cur_wdata = 32'h0;
    logic [3:0]  cur_wstrb = 4'h0;
    // per-transaction records
    int acc_cyc = 0, aw_n = 0, w_n = 0, ar_n = 0, b_n = 0, r_n = 0, bp_n = 0;
    int aw_first = -1, ar_first = -1, b_first = -1, rsp_first = -1;
    int stab_err = 0, bp_err = 0;
    logic cr_after = 1'b0, hs_prev = 1'b0, held_prev = 1'b0;
    logic [34:0] p_rsp = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        else n_pass++;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Slave model plus per-transaction recorder; drives slave inputs for the coming edge.
    always @(negedge clk) begin
        if (cmd_valid && cmd_ready) begin
            acc_cyc = cyc; aw_n = 0; w_n = 0; ar_n = 0; b_n = 0; r_n = 0; bp_n = 0;
            aw_first = -1; ar_first = -1; b_first = -1; rsp_first = -1; cr_after = 1'b0;
        end
        if (hs_prev) cr_after = cmd_ready;
        if (rsp_valid && held_prev && ({rsp_rdata, rsp_resp, rsp_timeout} != p_rsp)) bp_err++;
        if (rsp_valid && cmd_ready) bp_err++;
        if (rsp_valid && !rsp_ready) bp_n++;
        if (rsp_valid && rsp_first < 0) rsp_first = cyc - acc_cyc;
        held_prev = rsp_valid && !rsp_ready;
        hs_prev   = rsp_valid && rsp_ready;
        p_rsp     = {rsp_rdata, rsp_resp, rsp_timeout};
        if (M_AXI_AWVALID) begin
            if (aw_first < 0) aw_first = cyc - acc_cyc;
            aw_n++;
            if (M_AXI_AWADDR != cur_addr) stab_err++;
        end
        if (M_AXI_WVALID) begin
            w_n++;
            if ({M_AXI_WDATA, M_AXI_WSTRB} != {cur_wdata, cur_wstrb}) stab_err++;
        end
        if (M_AXI_ARVALID) begin
            if (ar_first < 0) ar_first = cyc - acc_cyc;
            ar_n++;
            if (M_AXI_ARADDR != cur_addr) stab_err++;
        end
        if (M_AXI_BREADY) begin
            if (b_first < 0) b_first = cyc - acc_cyc;
            b_n++;
        end
        if (M_AXI_RREADY) r_n++;
        M_AXI_AWREADY = M_AXI_AWVALID && (aw_n == aw_wait + 1);
        M_AXI_WREADY  = M_AXI_WVALID  && (w_n == w_wait + 1);
        M_AXI_ARREADY = M_AXI_ARVALID && (ar_n == ar_wait + 1);
        M_AXI_BVALID  = M_AXI_BREADY  && !b_never && (b_n == b_wait + 1);
        M_AXI_RVALID  = M_AXI_RREADY  && !r_never && (r_n == r_wait + 1);
        M_AXI_BRESP = resp_cfg;
        M_AXI_RRESP = resp_cfg;
        M_AXI_RDATA = rdata_cfg;
    end

    // Scoreboard monitor: every response handshake pops and compares one expected entry.
    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL rsp_unexpected: got rdata=0x%0h resp=%b to=%b with nothing expected",
                         rsp_rdata, rsp_resp, rsp_timeout);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_rdata", rsp_rdata, mon_e.rdata);
                chk("rsp_resp", rsp_resp, mon_e.resp);
                chk("rsp_timeout", rsp_timeout, mon_e.to);
            end
            n_rsp++;
        end
    end

    task automatic do_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [31:0] er, input logic [1:0] ersp, input logic eto, input int hold);
        int k;
        int n0;
        sb.push_back('{rdata: er, resp: ersp, to: eto});
        cur_addr = a; cur_wdata = d; cur_wstrb = s;
        n0 = n_rsp;
        @(posedge clk); #1;
        rsp_ready = (hold == 0);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        k = 0;
        do begin @(negedge clk); k++; end while (!cmd_ready && k < 50);
        if (!cmd_ready) begin
            n_chk++;
            $display("FAIL cmd_accept: cmd_ready=0 after %0d cycles, required 1", k);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        if (hold > 0) begin
            k = 0;
            while (!rsp_valid && k < 100) begin @(negedge clk); k++; end
            repeat (hold) @(posedge clk);
            #1 rsp_ready = 1'b1;
        end
        k = 0;
        while (n_rsp == n0 && k < 200) begin @(negedge clk); k++; end
        if (n_rsp == n0) begin
            n_chk++;
            $display("FAIL rsp_wait: no response after %0d cycles, required one", k);
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "bench stalled");
    end

    initial begin
        M_AXI_ARESET = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_handshakes", {cmd_ready, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
                               M_AXI_ARVALID, M_AXI_RREADY, rsp_valid}, 0);
        @(posedge clk); #1 M_AXI_ARESET = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_regs", {rsp_rdata, rsp_resp, rsp_timeout}, 0);
        chk("rst_addr_data", {M_AXI_AWADDR, M_AXI_WDATA}, 0);

        // zero-wait write
        do_cmd(1'b1, 32'h79C0_0004, 32'hDEAD_BEEF, 4'hF, 32'h0, 2'b00, 1'b0, 0);
        chk("zw_aw_first", aw_first, 1);
        chk("zw_aw_cycles", aw_n, 1);
        chk("zw_w_cycles", w_n, 1);
        chk("zw_bready_first", b_first, 2);
        chk("zw_rsp_first", rsp_first, 3);
        chk("zw_cmd_ready_after", cr_after, 1);

        // read with 3 ARREADY wait cycles
        ar_wait = 3; rdata_cfg = 32'h1234_5678;
        do_cmd(1'b0, 32'h79C0_000C, 32'h0, 4'h0, 32'h1234_5678, 2'b00, 1'b0, 0);
        chk("rd_ar_first", ar_first, 1);
        chk("rd_ar_cycles", ar_n, 4);
        chk("rd_no_bready", b_n, 0);
        chk("rd_rsp_first", rsp_first, 6);
        ar_wait = 0;

        // split write handshake: W at cycle 1, AW at cycle 4, SLVERR response
        aw_wait = 3; resp_cfg = 2'b10;
        do_cmd(1'b1, 32'h79C0_0010, 32'h0BAD_F00D, 4'h3, 32'h0, 2'b10, 1'b0, 0);
        chk("split_w_cycles", w_n, 1);
        chk("split_aw_cycles", aw_n, 4);
        chk("split_bready_first", b_first, 5);
        chk("split_rsp_first", rsp_first, 6);
        aw_wait = 0; resp_cfg = 2'b00;

        // watchdog: slave never answers the write
        b_never = 1;
        do_cmd(1'b1, 32'h79C0_0014, 32'h5555_AAAA, 4'hF, 32'h0, 2'b11, 1'b1, 0);
        chk("to_bready_first", b_first, 2);
        chk("to_bready_cycles", b_n, 16);
        chk("to_rsp_first", rsp_first, 18);
        b_never = 0;
        rdata_cfg = 32'hA5A5_0001;
        do_cmd(1'b0, 32'h79C0_0018, 32'h0, 4'h0, 32'hA5A5_0001, 2'b00, 1'b0, 0);
        chk("after_to_rsp_first", rsp_first, 3);

        // response backpressure for 10 cycles
        do_cmd(1'b1, 32'h79C0_0008, 32'h0000_00FF, 4'h1, 32'h0, 2'b00, 1'b0, 10);
        chk("bp_hold_cycles", bp_n, 10);
        chk("bp_cmd_ready_after", cr_after, 1);

        // reset while ARVALID is high
        ar_wait = 1000;
        cur_addr = 32'h79C0_0020;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h79C0_0020;
        @(negedge clk);
        chk("rr_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("rr_arvalid_before", M_AXI_ARVALID, 1);
        @(posedge clk); #1 M_AXI_ARESET = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rr_arvalid_after", M_AXI_ARVALID, 0);
        chk("rr_rsp_valid", rsp_valid, 0);
        @(posedge clk); #1 M_AXI_ARESET = 1'b0;
        @(negedge clk);
        chk("rr_idle_ready", cmd_ready, 1);
        ar_wait = 0; rdata_cfg = 32'hCAFE_F00D;
        repeat (3) @(posedge clk);
        do_cmd(1'b0, 32'h79C0_0024, 32'h0, 4'h0, 32'hCAFE_F00D, 2'b00, 1'b0, 0);
        chk("rr_next_rsp_first", rsp_first, 3);

        chk("addr_data_stability", stab_err, 0);
        chk("rsp_hold_stability", bp_err, 0);
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
